cpu_sequencer: RTL and testbench

//  Instruction timing sequencer and status-flag holder for the 16-bit CPU.

---
 rtl/cpu_sequencer.sv | 145 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Instruction timing sequencer and status-flag holder for the 16-bit CPU.
//   It latches the fetched word into IR' and drives the fetch/exec1/exec2
//   timing strobes. It also holds the CARRY and SKIP flip-flops for the ALU.
//
// Ports
//   clk            system clock; all state changes on the rising edge
//   reset          synchronous, active-high reset
//   mem_rdata      instruction word from memory
//   mem_valid      mem_rdata valid this cycle (only looked at in FETCH)
//   carryout/en    CARRY D input and enable from the ALU (EXEC1 only)
//   skipout/en     SKIP D input and enable from the ALU (EXEC1 only)
//   ir             IR' register to the ALU
//   fetch/exec1/exec2  one-hot timing strobes
//   pc_inc         1-cycle PC increment strobe (combinational)
//   carrystatus    CARRY flip-flop Q
//   skipstatus     SKIP flip-flop Q
//   fetch_timeout  sticky flag: FETCH waited WAIT_MAX cycles
//   halt_req/halted  only present when SEQ_HALT_EN is defined
//
// Build option
//   SEQ_HALT_EN    adds the HALT state and the halt_req/halted ports.
//
// state  | meaning
// FETCH  | wait for mem_valid, then accept the word or discard it on a pending skip
// EXEC1  | first execute cycle; the ALU may update CARRY/SKIP
// EXEC2  | second execute cycle, used only by memory ops (ir[15:14] = 01/10)
// HALT   | stalled on halt_req with the strobes low (SEQ_HALT_EN builds only)

module cpu_sequencer #(
  parameter logic [15:0] RESET_IR = 16'h0000,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid,
  input  logic        carryout,
  input  logic        carryen,
  input  logic        skipout,
  input  logic        skipen,
`ifdef SEQ_HALT_EN
  input  logic        halt_req,
  output logic        halted,
`endif
  output logic [15:0] ir,
  output logic        fetch,
  output logic        exec1,
  output logic        exec2,
  output logic        pc_inc,
  output logic        carrystatus,
  output logic        skipstatus,
  output logic        fetch_timeout
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC1 = 2'd1,
    S_EXEC2 = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_inc;
  logic       halt_go;
  logic       accept;
  logic       discard;
  logic       mem_op;

`ifdef SEQ_HALT_EN
  assign halt_go = halt_req;
  assign halted  = (state == S_HALT);
`else
  assign halt_go = 1'b0;
`endif

  assign mem_op = (ir[15:14] == 2'b01) || (ir[15:14] == 2'b10);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Next-state logic; a halt request wins over a valid word in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (halt_go)                       state_nxt = S_HALT;
        else if (mem_valid && !skipstatus) state_nxt = S_EXEC1;
      end
      S_EXEC1: state_nxt = mem_op ? S_EXEC2 : S_FETCH;
      S_EXEC2: state_nxt = S_FETCH;
      S_HALT:  if (!halt_go) state_nxt = S_FETCH;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Output decode
  always_comb begin
    fetch   = (state == S_FETCH);
    exec1   = (state == S_EXEC1);
    exec2   = (state == S_EXEC2);
    pc_inc  = fetch && mem_valid && !halt_go;
    accept  = pc_inc && !skipstatus;
    discard = pc_inc && skipstatus;
  end

  // The count saturates so that a long stall cannot wrap it back under the limit
  assign wait_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ir            <= RESET_IR;
      carrystatus   <= 1'b0;
      skipstatus    <= 1'b0;
      wait_cnt      <= 8'd0;
      fetch_timeout <= 1'b0;
    end else begin
      if (accept) ir <= mem_rdata;

      if (exec1 && carryen) carrystatus <= carryout;

      // Setting SKIP (EXEC1) and consuming it (FETCH) never happen in the same cycle
      if (exec1 && skipen) skipstatus <= skipout;
      else if (discard)    skipstatus <= 1'b0;

      if (fetch && !halt_go) begin
        if (mem_valid) begin
          wait_cnt <= 8'd0;
        end else begin
          wait_cnt <= wait_inc;
          if ((WAIT_MAX != 0) && (wait_inc == WAIT_LIM)) fetch_timeout <= 1'b1;
        end
      end else if (state != S_HALT) begin
        wait_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic        carryout, carryen, skipout, skipen;
  logic [15:0] ir;
  logic        fetch, exec1, exec2, pc_inc;
  logic        carrystatus, skipstatus, fetch_timeout;
`ifdef SEQ_HALT_EN
  logic        halt_req;
  logic        halted;
`endif

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [15:0] RST_IR = 16'h1234;

  cpu_sequencer #(.RESET_IR(RST_IR), .WAIT_MAX(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_rdata     (mem_rdata),
    .mem_valid     (mem_valid),
    .carryout      (carryout),
    .carryen       (carryen),
    .skipout       (skipout),
    .skipen        (skipen),
`ifdef SEQ_HALT_EN
    .halt_req      (halt_req),
    .halted        (halted),
`endif
    .ir            (ir),
    .fetch         (fetch),
    .exec1         (exec1),
    .exec2         (exec2),
    .pc_inc        (pc_inc),
    .carrystatus   (carrystatus),
    .skipstatus    (skipstatus),
    .fetch_timeout (fetch_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_rdata = 16'h0; mem_valid = 1'b0;
    carryout = 1'b0; carryen = 1'b0; skipout = 1'b0; skipen = 1'b0;
`ifdef SEQ_HALT_EN
    halt_req = 1'b0;
`endif
    tick(); tick();

    // Reset state
    check_val("rst_fetch", {31'd0, fetch}, 1);
    check_val("rst_exec1", {31'd0, exec1}, 0);
    check_val("rst_exec2", {31'd0, exec2}, 0);
    check_val("rst_ir", {16'd0, ir}, {16'd0, RST_IR});
    check_val("rst_carry", {31'd0, carrystatus}, 0);
    check_val("rst_skip", {31'd0, skipstatus}, 0);
    check_val("rst_tmo", {31'd0, fetch_timeout}, 0);

    // ARM word C000
    reset = 1'b0; mem_valid = 1'b1; mem_rdata = 16'hC000; #1;
    check_val("arm_pcinc", {31'd0, pc_inc}, 1);
    tick();
    check_val("arm_exec1", {31'd0, exec1}, 1);
    check_val("arm_ir", {16'd0, ir}, 32'hC000);
    check_val("arm_pcinc_e1", {31'd0, pc_inc}, 0);
    mem_valid = 1'b0;
    tick();
    check_val("arm_back_fetch", {31'd0, fetch}, 1);

    // Memory op 8123: FETCH, EXEC1, EXEC2, FETCH
    mem_valid = 1'b1; mem_rdata = 16'h8123;
    tick();
    check_val("mem_exec1", {31'd0, exec1}, 1);
    mem_valid = 1'b0;
    tick();
    check_val("mem_exec2", {31'd0, exec2}, 1);
    check_val("mem_e2_fetch", {31'd0, fetch}, 0);
    tick();
    check_val("mem_exec2_off", {31'd0, exec2}, 0);
    check_val("mem_fetch", {31'd0, fetch}, 1);

    // Carry set in EXEC1, ignored in FETCH
    mem_valid = 1'b1; mem_rdata = 16'hC001;
    tick();
    carryen = 1'b1; carryout = 1'b1; mem_valid = 1'b0;
    tick();
    check_val("carry_set", {31'd0, carrystatus}, 1);
    carryout = 1'b0;
    tick();
    check_val("carry_fetch_ign", {31'd0, carrystatus}, 1);
    carryen = 1'b0;

    // Skip set in EXEC1, consumed by the next word
    mem_valid = 1'b1; mem_rdata = 16'hC002;
    tick();
    check_val("skip_ir", {16'd0, ir}, 32'hC002);
    skipen = 1'b1; skipout = 1'b1; mem_valid = 1'b0;
    tick();
    check_val("skip_set", {31'd0, skipstatus}, 1);
    skipen = 1'b0; skipout = 1'b0;
    mem_valid = 1'b1; mem_rdata = 16'hFFFF; #1;
    check_val("skip_pcinc", {31'd0, pc_inc}, 1);
    tick();
    check_val("skip_stay_fetch", {31'd0, fetch}, 1);
    check_val("skip_ir_hold", {16'd0, ir}, 32'hC002);
    check_val("skip_clear", {31'd0, skipstatus}, 0);
    mem_rdata = 16'h4005;
    tick();
    check_val("skip_next_exec1", {31'd0, exec1}, 1);
    check_val("skip_next_ir", {16'd0, ir}, 32'h4005);
    mem_valid = 1'b0;
    tick();
    check_val("skip_next_exec2", {31'd0, exec2}, 1);
    tick();

    // Fetch timeout with WAIT_MAX = 3
    tick();
    check_val("tmo_w1", {31'd0, fetch_timeout}, 0);
    tick();
    check_val("tmo_w2", {31'd0, fetch_timeout}, 0);
    tick();
    check_val("tmo_w3", {31'd0, fetch_timeout}, 1);
    mem_valid = 1'b1; mem_rdata = 16'h0000;
    tick();
    check_val("tmo_exec1", {31'd0, exec1}, 1);
    mem_valid = 1'b0;
    tick();
    check_val("tmo_sticky", {31'd0, fetch_timeout}, 1);

    // Reset in EXEC2 with CARRY set
    mem_valid = 1'b1; mem_rdata = 16'h8000;
    tick();
    mem_valid = 1'b0;
    tick();
    check_val("rst2_in_exec2", {31'd0, exec2}, 1);
    check_val("rst2_carry_pre", {31'd0, carrystatus}, 1);
    reset = 1'b1;
    tick();
    check_val("rst2_fetch", {31'd0, fetch}, 1);
    check_val("rst2_exec2", {31'd0, exec2}, 0);
    check_val("rst2_ir", {16'd0, ir}, {16'd0, RST_IR});
    check_val("rst2_carry", {31'd0, carrystatus}, 0);
    check_val("rst2_skip", {31'd0, skipstatus}, 0);
    check_val("rst2_tmo", {31'd0, fetch_timeout}, 0);
    reset = 1'b0;

`ifdef SEQ_HALT_EN
    // Halt wins over a valid word
    halt_req = 1'b1; mem_valid = 1'b1; mem_rdata = 16'hC0DE; #1;
    check_val("halt_pcinc", {31'd0, pc_inc}, 0);
    tick();
    check_val("halt_halted", {31'd0, halted}, 1);
    check_val("halt_fetch", {31'd0, fetch}, 0);
    check_val("halt_ir", {16'd0, ir}, {16'd0, RST_IR});
    halt_req = 1'b0; mem_valid = 1'b0;
    tick();
    check_val("halt_release", {31'd0, fetch}, 1);
    check_val("halt_off", {31'd0, halted}, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
